// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared types and constants for the byte-wide RAM arbiter.
//                FSM state encoding, memory access sizes, mem_op bit
//                positions and the transfer-length helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int RAM_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    // mem_op = {unsigned, size[1:0]}
    localparam int MEM_OP_UNSIGNED = 2;

    // Number of byte transfers for an access. Size 11 falls into the word case.
    function automatic logic [2:0] xfer_len(input logic is_if, input logic [1:0] size);
        logic [2:0] len;
        if (is_if) begin
            len = 3'd4;
        end else begin
            case (size)
                MEM_SIZE_B: len = 3'd1;
                MEM_SIZE_H: len = 3'd2;
                MEM_SIZE_W: len = 3'd4;
                default:    len = 3'd4;
            endcase
        end
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_ld_ext.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ld_ext
//  Description : Combinational size/sign extension of an assembled load word.
//  Ports       : word_i  assembled little-endian word
//                op_i    {unsigned, size[1:0]}
//                data_o  extended load data
//  Revision    : 1.0  initial release
// ============================================================================
module mem_ld_ext
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  op_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = word_i;
        case (op_i[1:0])
            MEM_SIZE_B: data_o = op_i[MEM_OP_UNSIGNED] ? {24'h0, word_i[7:0]}
                                                       : {{24{word_i[7]}}, word_i[7:0]};
            MEM_SIZE_H: data_o = op_i[MEM_OP_UNSIGNED] ? {16'h0, word_i[15:0]}
                                                       : {{16{word_i[15]}}, word_i[15:0]};
            default:    data_o = word_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Arbitrates one byte-wide synchronous RAM between instruction
//                fetch and the MEM stage. Each access is sequenced as 1-4
//                byte transfers; loads are assembled little-endian.
//  Ports       : clk/rst            clock, async active-low reset
//                if_*               IF word-read request / result
//                mem_*              MEM load/store request / result
//                stall_o            MEM stage stall
//                ram_*              RAM byte port (read data 1 cycle latency)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_cancel_i,
    output logic              if_done_o,
    output logic [31:0]       if_rdata_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [2:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic              owner_if_q, owner_if_d;
    logic              we_q, we_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic [2:0]        w_cnt_nx;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [31:0]       w_asm;
    logic [31:0]       w_ext;

    assign w_cnt_nx  = cnt_q + 3'd1;
    assign w_addr_nx = base_q + {{(ADDR_W-3){1'b0}}, w_cnt_nx};

    // RAM data for the address driven in cycle cnt_q arrives while cnt_q+1,
    // so byte (cnt_q-1) is merged in with the byte currently on ram_din_i.
    always_comb begin
        w_asm = asm_q;
        case (cnt_q)
            3'd1:    w_asm[7:0]   = ram_din_i;
            3'd2:    w_asm[15:8]  = ram_din_i;
            3'd3:    w_asm[23:16] = ram_din_i;
            3'd4:    w_asm[31:24] = ram_din_i;
            default: ;
        endcase
    end

    mem_ld_ext u_ld_ext (
        .word_i (w_asm),
        .op_i   (op_q),
        .data_o (w_ext)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        owner_if_d  = owner_if_q;
        we_d        = we_q;
        op_d        = op_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        // RAM strobes and done pulses are zero unless a cycle drives them.
        ram_a_d     = '0;
        ram_wr_d    = 1'b0;
        ram_dout_d  = 8'h00;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_req_i) begin
                    state_d    = ST_BUSY;
                    cnt_d      = 3'd0;
                    len_d      = xfer_len(1'b0, mem_op_i[1:0]);
                    owner_if_d = 1'b0;
                    we_d       = mem_we_i;
                    op_d       = mem_op_i;
                    base_d     = mem_addr_i;
                    wdata_d    = mem_wdata_i;
                    asm_d      = 32'h0;
                    ram_a_d    = mem_addr_i;
                    ram_wr_d   = mem_we_i;
                    ram_dout_d = mem_we_i ? mem_wdata_i[7:0] : 8'h00;
                end else if (if_req_i) begin
                    state_d    = ST_BUSY;
                    cnt_d      = 3'd0;
                    len_d      = xfer_len(1'b1, 2'b00);
                    owner_if_d = 1'b1;
                    we_d       = 1'b0;
                    op_d       = 3'b000;
                    base_d     = if_addr_i;
                    asm_d      = 32'h0;
                    ram_a_d    = if_addr_i;
                end
            end

            ST_BUSY: begin
                if (owner_if_q && if_cancel_i) begin
                    state_d = ST_IDLE;
                end else if (we_q) begin
                    cnt_d = w_cnt_nx;
                    if (w_cnt_nx == len_q) begin
                        state_d    = ST_DONE;
                        mem_done_d = 1'b1;
                    end else begin
                        ram_a_d    = w_addr_nx;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = wdata_q[{w_cnt_nx[1:0], 3'b000} +: 8];
                    end
                end else begin
                    cnt_d = w_cnt_nx;
                    asm_d = w_asm;
                    if (w_cnt_nx < len_q) begin
                        ram_a_d = w_addr_nx;
                    end
                    // Last byte lands in the cycle after the final address.
                    if (cnt_q == len_q) begin
                        state_d = ST_DONE;
                        if (owner_if_q) begin
                            if_done_d  = 1'b1;
                            if_rdata_d = w_asm;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = w_ext;
                        end
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            owner_if_q  <= 1'b0;
            we_q        <= 1'b0;
            op_q        <= 3'b000;
            base_q      <= '0;
            wdata_q     <= 32'h0;
            asm_q       <= 32'h0;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'h00;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            owner_if_q  <= owner_if_d;
            we_q        <= we_d;
            op_q        <= op_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign if_done_o   = if_done_q;
    assign if_rdata_o  = if_rdata_q;
    assign mem_done_o  = mem_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign ram_a_o     = ram_a_q;
    assign ram_wr_o    = ram_wr_q;
    assign ram_dout_o  = ram_dout_q;
    assign stall_o     = mem_req_i & ~mem_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ctrl
//  Description : Scoreboard bench for mem_ctrl with a behavioural byte RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'h0;
    logic        if_cancel_i = 1'b0;
    logic        if_done_o;
    logic [31:0] if_rdata_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [2:0]  mem_op_i = 3'b000;
    logic [31:0] mem_addr_i = 32'h0;
    logic [31:0] mem_wdata_i = 32'h0;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic        stall_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i = 8'h00;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_cancel_i (if_cancel_i),
        .if_done_o   (if_done_o),
        .if_rdata_o  (if_rdata_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_done_o  (mem_done_o),
        .mem_rdata_o (mem_rdata_o),
        .stall_o     (stall_o),
        .ram_a_o     (ram_a_o),
        .ram_wr_o    (ram_wr_o),
        .ram_dout_o  (ram_dout_o),
        .ram_din_i   (ram_din_i)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: 4 KiB, address aliased on the low 12 bits.
    logic [7:0] ram [0:4095];
    always @(posedge clk) begin
        ram_din_i <= ram[ram_a_o[11:0]];
        if (ram_wr_o) ram[ram_a_o[11:0]] = ram_dout_o;
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] if_q  [$];
    logic [31:0] mem_q [$];
    logic [39:0] wr_q  [$];

    time t_if_done  = 0;
    time t_mem_done = 0;

    task automatic chk(input bit ok, input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitor
    logic [31:0] m_e;
    logic [39:0] m_w;
    always @(negedge clk) begin
        if (rst) begin
            if (if_done_o) begin
                if (if_q.size() == 0) chk(1'b0, "if_unexpected_done", {8'h0, if_rdata_o}, 40'h0);
                else begin
                    m_e = if_q.pop_front();
                    chk(if_rdata_o == m_e, "if_rdata", {8'h0, if_rdata_o}, {8'h0, m_e});
                end
            end
            if (mem_done_o) begin
                if (mem_q.size() == 0) chk(1'b0, "mem_unexpected_done", {8'h0, mem_rdata_o}, 40'h0);
                else begin
                    m_e = mem_q.pop_front();
                    chk(mem_rdata_o == m_e, "mem_rdata", {8'h0, mem_rdata_o}, {8'h0, m_e});
                end
            end
            if (ram_wr_o) begin
                if (wr_q.size() == 0) chk(1'b0, "unexpected_write", {ram_a_o, ram_dout_o}, 40'h0);
                else begin
                    m_w = wr_q.pop_front();
                    chk({ram_a_o, ram_dout_o} == m_w, "ram_write", {ram_a_o, ram_dout_o}, m_w);
                end
            end
        end
    end

    // MEM access; exp_rdata is the hand-computed mem_rdata_o at done.
    task automatic run_mem(input bit we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit strict);
        int n;
        int done_cyc;
        bit seen;
        logic [31:0] ea;
        n = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        mem_q.push_back(exp_rdata);
        if (we) for (int i = 0; i < n; i++) wr_q.push_back({addr + 32'(i), wdata[8*i +: 8]});
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_we_i = we; mem_op_i = op; mem_addr_i = addr; mem_wdata_i = wdata;
        seen = 1'b0; done_cyc = -1;
        for (int c = 0; c < 24 && !seen; c++) begin
            @(negedge clk);
            if (strict && c >= 1 && c <= n) begin
                ea = addr + 32'(c - 1);
                chk(ram_a_o == ea, "mem_ram_addr", {8'h0, ram_a_o}, {8'h0, ea});
                chk(ram_wr_o == we, "mem_ram_wr", {39'h0, ram_wr_o}, {39'h0, we});
            end
            if (mem_done_o) begin
                seen = 1'b1; done_cyc = c; t_mem_done = $time;
            end else begin
                chk(stall_o == 1'b1, "stall_busy", {39'h0, stall_o}, 40'h1);
            end
        end
        if (!seen) chk(1'b0, "mem_timeout", 40'h0, 40'h1);
        else begin
            chk(stall_o == 1'b0, "stall_at_done", {39'h0, stall_o}, 40'h0);
            if (strict) chk(done_cyc == (we ? n + 1 : n + 2), "mem_done_cycle",
                            40'(done_cyc), 40'(we ? n + 1 : n + 2));
        end
        @(posedge clk); #1;
        mem_req_i = 1'b0; mem_we_i = 1'b0;
    endtask

    // IF fetch; cancel_cyc < 0 means run to completion.
    task automatic run_if(input logic [31:0] addr, input logic [31:0] exp_rdata,
                          input int cancel_cyc, input bit strict);
        int done_cyc;
        bit seen;
        int limit;
        logic [31:0] ea;
        if (cancel_cyc < 0) if_q.push_back(exp_rdata);
        limit = (cancel_cyc < 0) ? 30 : cancel_cyc + 6;
        @(posedge clk); #1;
        if_req_i = 1'b1; if_addr_i = addr;
        seen = 1'b0; done_cyc = -1;
        for (int c = 0; c < limit && !seen; c++) begin
            @(negedge clk);
            if (strict && c >= 1 && c <= 4 && (cancel_cyc < 0 || c <= cancel_cyc)) begin
                ea = addr + 32'(c - 1);
                chk(ram_a_o == ea, "if_ram_addr", {8'h0, ram_a_o}, {8'h0, ea});
                chk(ram_wr_o == 1'b0, "if_ram_wr", {39'h0, ram_wr_o}, 40'h0);
            end
            if (cancel_cyc >= 0 && c == cancel_cyc) begin
                if_cancel_i = 1'b1; if_req_i = 1'b0;
            end
            if (cancel_cyc >= 0 && c == cancel_cyc + 1) begin
                chk(ram_a_o == 32'h0, "cancel_idle_addr", {8'h0, ram_a_o}, 40'h0);
                if_cancel_i = 1'b0;
            end
            if (cancel_cyc < 0 && if_done_o) begin
                seen = 1'b1; done_cyc = c; t_if_done = $time;
            end
        end
        if (cancel_cyc < 0) begin
            if (!seen) chk(1'b0, "if_timeout", 40'h0, 40'h1);
            else if (strict) chk(done_cyc == 6, "if_done_cycle", 40'(done_cyc), 40'd6);
        end
        @(posedge clk); #1;
        if_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'h200] = 8'h80;
        ram[12'h400] = 8'h80; ram[12'h401] = 8'hFF;
        ram[12'h500] = 8'hDE; ram[12'h501] = 8'hAD; ram[12'h502] = 8'hBE; ram[12'h503] = 8'hEF;
        ram[12'hFFE] = 8'h01; ram[12'hFFF] = 8'h02; ram[12'h000] = 8'h03; ram[12'h001] = 8'h04;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({ram_a_o, ram_wr_o, ram_dout_o, if_done_o, mem_done_o} == 43'h0, "reset_ram_done",
            {ram_a_o, ram_dout_o}, 40'h0);
        chk(if_rdata_o == 32'h0, "reset_if_rdata", {8'h0, if_rdata_o}, 40'h0);
        chk(mem_rdata_o == 32'h0, "reset_mem_rdata", {8'h0, mem_rdata_o}, 40'h0);
        rst = 1'b1;

        // 1. IF read
        run_if(32'h100, 32'h44332211, -1, 1'b1);

        // 2. Simultaneous IF and MEM LB: MEM wins
        fork
            run_mem(1'b0, 3'b000, 32'h200, 32'h0, 32'hFFFFFF80, 1'b1);
            run_if(32'h100, 32'h44332211, -1, 1'b0);
        join
        chk(t_mem_done < t_if_done, "mem_priority", 40'(t_mem_done), 40'(t_if_done));

        // 3. SH, mem_rdata_o must keep the previous load value
        run_mem(1'b1, 3'b001, 32'h300, 32'h00001234, 32'hFFFFFF80, 1'b1);
        run_mem(1'b0, 3'b001, 32'h300, 32'h0, 32'h00001234, 1'b1);
        run_mem(1'b0, 3'b000, 32'h301, 32'h0, 32'h00000012, 1'b1);

        // 4. Halfword extension, byte zero-extension, word and illegal size
        run_mem(1'b0, 3'b101, 32'h400, 32'h0, 32'h0000FF80, 1'b1);
        run_mem(1'b0, 3'b001, 32'h400, 32'h0, 32'hFFFFFF80, 1'b1);
        run_mem(1'b0, 3'b100, 32'h200, 32'h0, 32'h00000080, 1'b1);
        run_mem(1'b0, 3'b010, 32'h100, 32'h0, 32'h44332211, 1'b1);
        run_mem(1'b0, 3'b011, 32'h100, 32'h0, 32'h44332211, 1'b1);
        // Address wrap at the top of the address space
        run_mem(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h04030201, 1'b1);

        // 5. IF cancel in cycle 3, then a normal fetch
        run_if(32'h100, 32'h0, 3, 1'b1);
        run_if(32'h500, 32'hEFBEADDE, -1, 1'b1);

        // 6. Async reset mid-cycle 2 of an SW
        wr_q.push_back({32'h600, 8'hA5});
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_op_i = 3'b010;
        mem_addr_i = 32'h600; mem_wdata_i = 32'hA5A5A5A5;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        #1;
        chk(ram_wr_o == 1'b0, "rst_ram_wr", {39'h0, ram_wr_o}, 40'h0);
        chk({ram_a_o, ram_dout_o} == 40'h0, "rst_ram_a_dout", {ram_a_o, ram_dout_o}, 40'h0);
        chk({if_done_o, mem_done_o, stall_o} == 3'b000, "rst_flags",
            {37'h0, if_done_o, mem_done_o, stall_o}, 40'h0);
        chk({if_rdata_o, mem_rdata_o} == 64'h0, "rst_rdata", {8'h0, mem_rdata_o}, 40'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_mem(1'b1, 3'b010, 32'h600, 32'h87654321, 32'h00000000, 1'b1);
        run_mem(1'b0, 3'b010, 32'h600, 32'h0, 32'h87654321, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(if_q.size() == 0, "if_queue_empty", 40'(if_q.size()), 40'h0);
        chk(mem_q.size() == 0, "mem_queue_empty", 40'(mem_q.size()), 40'h0);
        chk(wr_q.size() == 0, "wr_queue_empty", 40'(wr_q.size()), 40'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
